// File: rtl/keypad_scan_unit.sv
// 4x4 matrix keypad scanner: row rotation, column synchronisation, frame-level
// debounce and a one-cycle {row,col} event per accepted press.
module keypad_scan_unit #(
  parameter logic [15:0] SCAN_DIV        = 16'd50000,
  parameter logic [3:0]  DEBOUNCE_FRAMES = 4'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [7:0] key_coord,
  output logic       key_held
);

  typedef enum logic {RELEASED, PRESSED} state_t;

  state_t      state;
  logic [3:0]  col_meta;
  logic [3:0]  col_sync;
  logic [15:0] slot_cnt;
  logic [1:0]  row_idx;
  logic [3:0]  frame_buf [3];
  logic [7:0]  cand;
  logic [3:0]  stable_cnt;
  logic        armed;

  logic        slot_end;
  logic        frame_end;
  logic [3:0]  cols_all [4];
  logic [7:0]  frame_code;
  logic [3:0]  cnt_next;
  logic        stable;

  assign slot_end  = (slot_cnt == SCAN_DIV - 16'd1);
  assign frame_end = slot_end && (row_idx == 2'd3);

  // Row 3 is still live in col_sync on the frame-end cycle, so it bypasses the buffer.
  always_comb begin
    logic [3:0] inv;
    logic [2:0] hits;
    logic       bad;
    logic [7:0] hit_code;
    cols_all[0] = frame_buf[0];
    cols_all[1] = frame_buf[1];
    cols_all[2] = frame_buf[2];
    cols_all[3] = col_sync;
    hits        = '0;
    bad         = 1'b0;
    hit_code    = '0;
    inv         = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      inv = ~cols_all[r];
      if (inv != 4'd0) begin
        if ((inv & (inv - 4'd1)) == 4'd0) begin
          hits     = hits + 3'd1;
          hit_code = {~(4'b0001 << r), cols_all[r]};
        end else begin
          bad = 1'b1;
        end
      end
    end
    frame_code = (hits == 3'd1 && !bad) ? hit_code : 8'h00;
  end

  always_comb begin
    cnt_next = 4'd1;
    if (frame_code == cand) begin
      if (stable_cnt >= DEBOUNCE_FRAMES)
        cnt_next = DEBOUNCE_FRAMES;
      else
        cnt_next = stable_cnt + 4'd1;
    end
    stable = (cnt_next == DEBOUNCE_FRAMES);
  end

  // armed starts low so a key held through reset must be seen released before it can fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RELEASED;
      col_meta     <= 4'hF;
      col_sync     <= 4'hF;
      slot_cnt     <= '0;
      row_idx      <= '0;
      row_out      <= 4'b1110;
      frame_buf[0] <= 4'hF;
      frame_buf[1] <= 4'hF;
      frame_buf[2] <= 4'hF;
      cand         <= '0;
      stable_cnt   <= '0;
      armed        <= 1'b0;
      key_coord    <= '0;
      key_held     <= 1'b0;
    end else begin
      col_meta  <= col_in;
      col_sync  <= col_meta;
      key_coord <= '0;

      if (slot_end) begin
        slot_cnt <= '0;
        row_idx  <= row_idx + 2'd1;
        row_out  <= {row_out[2:0], row_out[3]};
        case (row_idx)
          2'd0:    frame_buf[0] <= col_sync;
          2'd1:    frame_buf[1] <= col_sync;
          2'd2:    frame_buf[2] <= col_sync;
          default: ;
        endcase
      end else begin
        slot_cnt <= slot_cnt + 16'd1;
      end

      if (frame_end) begin
        cand       <= frame_code;
        stable_cnt <= cnt_next;
        if (stable) begin
          case (state)
            RELEASED: begin
              if (frame_code == 8'h00) begin
                armed <= 1'b1;
              end else if (armed) begin
                state     <= PRESSED;
                key_coord <= frame_code;
                key_held  <= 1'b1;
              end
            end
            PRESSED: begin
              if (frame_code == 8'h00) begin
                state    <= RELEASED;
                armed    <= 1'b1;
                key_held <= 1'b0;
              end
            end
            default: state <= RELEASED;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_unit.sv
// Bench for keypad_scan_unit: physical keypad model, frame-level reference model,
// per-cycle comparison and directed/random key scenarios.
module tb_keypad_scan_unit;

  localparam int SD = 4;
  localparam int DF = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [7:0] key_coord;
  logic       key_held;

  logic [15:0] keys;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] pulses [$];

  keypad_scan_unit #(.SCAN_DIV(16'd4), .DEBOUNCE_FRAMES(4'd2)) dut (
    .clk(clk), .rst(rst), .col_in(col_in),
    .row_out(row_out), .key_coord(key_coord), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_out[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) col_in[c] = 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: cycle count since reset determines row/slot; frames judged by total low count.
  int         m_cyc;
  logic [3:0] m_s1, m_s2;
  logic [3:0] m_fb [4];
  logic [7:0] m_cand;
  int         m_cnt;
  bit         m_pressed, m_armed;
  logic [7:0] exp_coord;
  bit         exp_held;
  logic [3:0] exp_row;

  always @(posedge clk or posedge rst) begin
    int ri, lows, rr, cc;
    logic [7:0] code;
    logic [3:0] rp, cp;
    if (rst) begin
      m_cyc = 0; m_s1 = 4'hF; m_s2 = 4'hF;
      for (int i = 0; i < 4; i++) m_fb[i] = 4'hF;
      m_cand = 8'h00; m_cnt = 0; m_pressed = 0; m_armed = 0;
      exp_coord = 8'h00; exp_held = 0; exp_row = 4'b1110;
    end else begin
      exp_coord = 8'h00;
      ri = (m_cyc / SD) % 4;
      if (m_cyc % SD == SD - 1) begin
        m_fb[ri] = m_s2;
        if (ri == 3) begin
          lows = 0; rr = 0; cc = 0;
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              if (!m_fb[r][c]) begin lows++; rr = r; cc = c; end
          rp = ~(4'b0001 << rr);
          cp = ~(4'b0001 << cc);
          code = (lows == 1) ? {rp, cp} : 8'h00;
          if (code == m_cand) m_cnt = (m_cnt < DF) ? m_cnt + 1 : DF;
          else begin m_cand = code; m_cnt = 1; end
          if (m_cnt == DF) begin
            if (m_cand == 8'h00) begin
              m_armed = 1; m_pressed = 0; exp_held = 0;
            end else if (!m_pressed && m_armed) begin
              m_pressed = 1; exp_held = 1; exp_coord = m_cand;
            end
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = col_in;
      m_cyc++;
      exp_row = ~(4'b0001 << ((m_cyc / SD) % 4));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("row_out", row_out, exp_row);
      chk("key_coord", key_coord, exp_coord);
      chk("key_held", key_held, exp_held);
      if (key_coord != 8'h00) pulses.push_back(key_coord);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulses(input string nm, input int n, input logic [7:0] v);
    chk({nm, " pulse count"}, pulses.size(), n);
    foreach (pulses[i]) chk({nm, " pulse value"}, pulses[i], v);
    pulses.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  localparam logic [15:0] K5 = 16'h0020, KA = 16'h0008, K1 = 16'h0001, K2 = 16'h0002;
  localparam logic [15:0] KH = 16'h4000, KB = 16'h0080, KC = 16'h0800;

  initial begin
    logic [3:0] row_lut [4];
    int k, n;
    row_lut[0] = 4'b1110; row_lut[1] = 4'b1101; row_lut[2] = 4'b1011; row_lut[3] = 4'b0111;
    keys = '0;
    rst  = 1'b1;
    cycles(3);
    chk("reset row_out", row_out, 4'b1110);
    chk("reset key_coord", key_coord, 8'h00);
    chk("reset key_held", key_held, 1'b0);
    rst = 1'b0;

    // Idle scanning: fixed row rotation, no events.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle row", row_out, row_lut[((i + 1) / SD) % 4]);
      chk("idle coord", key_coord, 8'h00);
      chk("idle held", key_held, 1'b0);
    end
    expect_pulses("idle", 0, 8'h00);

    // Key "5".
    cycles($urandom_range(0, 15));
    keys = K5; cycles(80);
    chk("5 held", key_held, 1'b1);
    keys = '0; cycles(64);
    chk("5 released", key_held, 1'b0);
    expect_pulses("key5", 1, 8'hDD);

    // Key "A" chatter aligned so alternate frames disagree, then held.
    k = 0;
    while (row_out !== 4'b1101 && k < 20) begin @(negedge clk); k++; end
    chk("chatter align", row_out, 4'b1101);
    n = $urandom_range(4, 6);
    for (int i = 0; i < n; i++) begin
      keys = keys ^ KA;
      cycles(16);
    end
    expect_pulses("chatter", 0, 8'h00);
    keys = KA; cycles(80);
    expect_pulses("keyA", 1, 8'hE7);
    keys = '0; cycles(64);

    // Ghosting: "1"+"2" together, then release "2".
    cycles($urandom_range(0, 15));
    keys = K1 | K2; cycles(80);
    expect_pulses("ghost", 0, 8'h00);
    keys = K1; cycles(80);
    expect_pulses("key1", 1, 8'hEE);
    keys = '0; cycles(64);

    // "#" held across a reset.
    keys = KH; cycles(80);
    expect_pulses("hash", 1, 8'h7B);
    rst = 1'b1; cycles(3); rst = 1'b0;
    cycles(96);
    chk("hash after reset held", key_held, 1'b0);
    expect_pulses("hash after reset", 0, 8'h00);
    keys = '0; cycles(64);
    keys = KH; cycles(80);
    expect_pulses("hash repress", 1, 8'h7B);
    keys = '0; cycles(64);

    // Roll "B" -> "C", then release and press "C".
    keys = KB; cycles(80);
    expect_pulses("keyB", 1, 8'hD7);
    keys = KC; cycles(80);
    chk("roll held", key_held, 1'b1);
    expect_pulses("roll", 0, 8'h00);
    keys = '0; cycles(64);
    chk("roll released", key_held, 1'b0);
    keys = KC; cycles(80);
    expect_pulses("keyC", 1, 8'hB7);
    keys = '0; cycles(64);

    // Random key activity: none, one or two keys for random durations.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 2))
        0:       keys = '0;
        1:       keys = 16'h0001 << $urandom_range(0, 15);
        default: keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      endcase
      cycles($urandom_range(1, 48));
    end
    keys = '0; cycles(80);
    pulses.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
